// File: rtl/max_tree_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : max_tree_sched_if
//  Description : Beat input handshake and max tree issue bus for
//                max_tree_sched. The slave modport is the scheduler side,
//                the master modport is the producer/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface max_tree_sched_if;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [1:0]    i_in_mode;
    logic [255:0]  i_in_data;
    logic          i_flush;
    logic          i_out_ready;
    logic          o_tree_en;
    logic [63:0]   o_tree_valid;
    logic [1:0]    o_tree_mode;
    logic [1023:0] o_tree_data;
    logic [2:0]    o_tree_rows;
    logic          o_busy;
    logic          o_err;
    logic [15:0]   o_issue_cnt;

    modport slave (
        input  i_in_valid, i_in_mode, i_in_data, i_flush, i_out_ready,
        output o_in_ready, o_tree_en, o_tree_valid, o_tree_mode, o_tree_data,
               o_tree_rows, o_busy, o_err, o_issue_cnt
    );

    modport master (
        output i_in_valid, i_in_mode, i_in_data, i_flush, i_out_ready,
        input  o_in_ready, o_tree_en, o_tree_valid, o_tree_mode, o_tree_data,
               o_tree_rows, o_busy, o_err, o_issue_cnt
    );
endinterface
`default_nettype wire

// File: rtl/max_tree_sched.sv
`default_nettype none
// ============================================================================
//  Module      : max_tree_sched
//  Description : Packs 256-bit input beats into a 4-beat (64-lane) buffer
//                and issues it to a max tree. Rows are 1, 2 or 4 beats long;
//                a partial buffer is issued at a row boundary on mode change,
//                flush or idle timeout. Unfilled lanes read as 16'h8000 so
//                they never win a signed max.
//  Revision    : 1.0  initial release
// ============================================================================
module max_tree_sched #(
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    max_tree_sched_if.slave   bus
);

    localparam logic [7:0]  c_timeout = 8'(TIMEOUT);
    localparam logic [15:0] c_min_val = 16'h8000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_ptr;
    logic [1:0]    r_mode;
    logic [7:0]    r_idle;
    logic          r_flush_pend;
    logic          r_err;
    logic [15:0]   r_issue_cnt;
    logic [255:0]  r_buf [4];

    logic          w_at_boundary;
    logic          w_boundary_stop;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_issue;
    logic          w_wr_en;
    logic [1:0]    w_wr_idx;
    logic [2:0]    w_rows;
    logic [63:0]   w_fill_mask;
    logic [1023:0] w_fill_data;

    // Row boundary: write pointer sits on a multiple of the row length.
    // Mode 0 rows span the whole buffer, so inside FILL it never lands on one.
    always_comb begin
        w_at_boundary = 1'b0;
        case (r_mode)
            2'd0:    w_at_boundary = (r_ptr[1:0] == 2'd0);
            2'd1:    w_at_boundary = (r_ptr[0] == 1'b0);
            default: w_at_boundary = 1'b1;
        endcase
    end

    // Any reason to close the buffer early; flush beats acceptance.
    assign w_boundary_stop = (r_state == ST_FILL) && w_at_boundary &&
                             (r_flush_pend || bus.i_flush ||
                              (r_idle == c_timeout) ||
                              (bus.i_in_valid && (bus.i_in_mode != r_mode)));

    // Input ready: open in EMPTY and in FILL unless the buffer is closing.
    always_comb begin
        w_in_ready = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                ST_EMPTY: w_in_ready = 1'b1;
                ST_FILL:  w_in_ready = !w_boundary_stop;
                default:  w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = bus.i_in_valid && w_in_ready;
    assign w_issue  = (r_state == ST_ISSUE) && bus.i_out_ready;

    // Mode-3 beats arriving in EMPTY are dropped without a buffer write.
    assign w_wr_en  = w_accept &&
                      ((r_state != ST_EMPTY) || (bus.i_in_mode != 2'd3));
    assign w_wr_idx = (r_state == ST_EMPTY) ? 2'd0 : r_ptr[1:0];

    // Scheduler state, pointer, idle counter, deferred flush and status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_EMPTY;
            r_ptr        <= 3'd0;
            r_mode       <= 2'd0;
            r_idle       <= 8'd0;
            r_flush_pend <= 1'b0;
            r_err        <= 1'b0;
            r_issue_cnt  <= 16'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_idle       <= 8'd0;
                    r_flush_pend <= 1'b0;
                    if (w_accept) begin
                        if (bus.i_in_mode == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode  <= bus.i_in_mode;
                            r_ptr   <= 3'd1;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_boundary_stop) begin
                        r_state <= ST_ISSUE;
                        r_idle  <= 8'd0;
                    end else if (w_accept) begin
                        r_ptr  <= r_ptr + 3'd1;
                        r_idle <= 8'd0;
                        if (r_ptr == 3'd3) begin
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_at_boundary) begin
                        if (r_idle != 8'hFF) begin
                            r_idle <= r_idle + 8'd1;
                        end
                    end else begin
                        r_idle <= 8'd0;
                    end
                    // Mid-row flush is remembered until the row completes.
                    if (!w_at_boundary && bus.i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.i_out_ready) begin
                        r_state      <= ST_EMPTY;
                        r_ptr        <= 3'd0;
                        r_idle       <= 8'd0;
                        r_flush_pend <= 1'b0;
                        r_issue_cnt  <= r_issue_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Beat storage; contents are only visible through the filled-beat mask.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= bus.i_in_data;
        end
    end

    // Per-beat lane valid mask and min-value padding of unfilled beats.
    generate
        for (genvar b = 0; b < 4; b++) begin : g_beat
            logic w_filled;
            assign w_filled = (3'(b) < r_ptr);
            assign w_fill_mask[16*b +: 16]  = w_filled ? 16'hFFFF : 16'h0000;
            assign w_fill_data[256*b +: 256] = w_filled ? r_buf[b]
                                                        : {16{c_min_val}};
        end
    endgenerate

    // Complete rows = filled beats / beats per row.
    always_comb begin
        w_rows = 3'd0;
        case (r_mode)
            2'd0:    w_rows = {2'b00, r_ptr[2]};
            2'd1:    w_rows = {1'b0, r_ptr[2:1]};
            default: w_rows = r_ptr;
        endcase
    end

    assign bus.o_in_ready   = w_in_ready;
    assign bus.o_tree_en    = bus.i_out_ready;
    assign bus.o_tree_valid = w_issue ? w_fill_mask : 64'd0;
    assign bus.o_tree_mode  = r_mode;
    assign bus.o_tree_data  = i_rst_n ? w_fill_data : 1024'd0;
    assign bus.o_tree_rows  = w_rows;
    assign bus.o_busy       = (r_state != ST_EMPTY);
    assign bus.o_err        = r_err;
    assign bus.o_issue_cnt  = r_issue_cnt;

endmodule
`default_nettype wire
